// File: rtl/max7219_sequencer.sv
// Command sequencer for two daisy-chained MAX7219 matrix drivers.
// Emits one register/data word pair per SPI frame: no-op, init block, then row refresh.
module max7219_sequencer #(
  parameter logic [2:0] SCAN_LIMIT = 3'd7,
  parameter logic [7:0] DECODE     = 8'h00
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        finish,
  input  logic [63:0] fb_a,
  input  logic [63:0] fb_b,
  input  logic [3:0]  intensity,
  input  logic        reinit,
  output logic [15:0] address,
  output logic [15:0] data,
  output logic        init_done,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_NOP,
    ST_INIT,
    ST_ROW
  } state_t;

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic [3:0]  row_reg;
  logic [63:0] snap_a_reg;
  logic [63:0] snap_b_reg;
  logic        pending_reg;
  logic [15:0] address_reg;
  logic [15:0] data_reg;
  logic        init_done_reg;
  logic        frame_done_reg;

  // Register address and value for init step k; both devices get the same command.
  function automatic logic [15:0] init_reg(input logic [2:0] k);
    logic [7:0] r;
    r = 8'h00;
    case (k)
      3'd0:    r = 8'h0C;
      3'd1:    r = 8'h09;
      3'd2:    r = 8'h0B;
      3'd3:    r = 8'h0A;
      3'd4:    r = 8'h0F;
      default: r = 8'h00;
    endcase
    return {r, r};
  endfunction

  function automatic logic [15:0] init_val(input logic [2:0] k, input logic [3:0] inten);
    logic [7:0] v;
    v = 8'h00;
    case (k)
      3'd0:    v = 8'h01;
      3'd1:    v = DECODE;
      3'd2:    v = {5'b0, SCAN_LIMIT};
      3'd3:    v = {4'b0, inten};
      default: v = 8'h00;
    endcase
    return {v, v};
  endfunction

  // Row r (1..8) occupies bits [8r-1:8r-8] of a bitmap.
  function automatic logic [7:0] row_byte(input logic [63:0] fb, input logic [3:0] r);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      if (r == 4'(i)) b = fb[8*i-1 -: 8];
    end
    return b;
  endfunction

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_NOP;
      idx_reg        <= 3'd0;
      row_reg        <= 4'd1;
      snap_a_reg     <= 64'd0;
      snap_b_reg     <= 64'd0;
      pending_reg    <= 1'b0;
      address_reg    <= 16'h0000;
      data_reg       <= 16'h0000;
      init_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (reinit) pending_reg <= 1'b1;

      if (finish) begin
        // A pending (or simultaneous) reinit overrides the normal transition.
        if (pending_reg || reinit) begin
          state_reg     <= ST_INIT;
          idx_reg       <= 3'd0;
          address_reg   <= init_reg(3'd0);
          data_reg      <= init_val(3'd0, intensity);
          init_done_reg <= 1'b0;
          pending_reg   <= 1'b0;
        end else begin
          case (state_reg)
            ST_NOP: begin
              state_reg   <= ST_INIT;
              idx_reg     <= 3'd0;
              address_reg <= init_reg(3'd0);
              data_reg    <= init_val(3'd0, intensity);
            end
            ST_INIT: begin
              if (idx_reg < 3'd4) begin
                idx_reg     <= idx_reg + 3'd1;
                address_reg <= init_reg(idx_reg + 3'd1);
                data_reg    <= init_val(idx_reg + 3'd1, intensity);
              end else begin
                state_reg     <= ST_ROW;
                row_reg       <= 4'd1;
                snap_a_reg    <= fb_a;
                snap_b_reg    <= fb_b;
                address_reg   <= 16'h0101;
                data_reg      <= {row_byte(fb_a, 4'd1), row_byte(fb_b, 4'd1)};
                init_done_reg <= 1'b1;
              end
            end
            ST_ROW: begin
              if (row_reg < 4'd8) begin
                row_reg     <= row_reg + 4'd1;
                address_reg <= {4'h0, row_reg + 4'd1, 4'h0, row_reg + 4'd1};
                data_reg    <= {row_byte(snap_a_reg, row_reg + 4'd1),
                                row_byte(snap_b_reg, row_reg + 4'd1)};
              end else begin
                // Wrap to row 1 with a fresh snapshot so a whole pass is tear-free.
                row_reg        <= 4'd1;
                snap_a_reg     <= fb_a;
                snap_b_reg     <= fb_b;
                address_reg    <= 16'h0101;
                data_reg       <= {row_byte(fb_a, 4'd1), row_byte(fb_b, 4'd1)};
                frame_done_reg <= 1'b1;
              end
            end
            default: begin
              state_reg     <= ST_NOP;
              address_reg   <= 16'h0000;
              data_reg      <= 16'h0000;
              init_done_reg <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign address    = address_reg;
  assign data       = data_reg;
  assign init_done  = init_done_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_max7219_sequencer.sv
// Scoreboard bench for max7219_sequencer: stimulus queues expected words, a monitor checks them.
module tb_max7219_sequencer;

  logic        sck = 1'b0;
  logic        rst = 1'b0;
  logic        finish = 1'b0;
  logic [63:0] fb_a = 64'd0;
  logic [63:0] fb_b = 64'd0;
  logic [3:0]  intensity = 4'd0;
  logic        reinit = 1'b0;
  logic [15:0] address;
  logic [15:0] data;
  logic        init_done;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic        id;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_word = '0;
  int   total = 0;
  int   bad = 0;

  max7219_sequencer dut (
    .sck(sck), .rst(rst), .finish(finish), .fb_a(fb_a), .fb_b(fb_b),
    .intensity(intensity), .reinit(reinit), .address(address), .data(data),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 sck = ~sck;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got addr/data/init/fd=%h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] row_word(input logic [63:0] a, input logic [63:0] b, input int r);
    return {a[8*r-1 -: 8], b[8*r-1 -: 8]};
  endfunction

  // Monitor: compares on every finish edge, checks hold/no-pulse between, zeros under reset.
  always @(posedge sck or posedge rst) begin
    logic f;
    exp_t e;
    if (rst) begin
      #1;
      check("reset", {address, data, init_done, frame_done}, 34'd0);
      last_word = '0;
    end else begin
      f = finish;
      #1;
      if (f) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {address, data, init_done, frame_done}, 34'h3_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word", {address, data, init_done, frame_done}, {e.a, e.d, e.id, e.fd});
          $display("word addr=%h data=%h init_done=%b frame_done=%b", address, data, init_done, frame_done);
          last_word = e;
          last_word.fd = 1'b0;
        end
      end else if (!rst) begin
        check("hold", {address, data, init_done, frame_done},
              {last_word.a, last_word.d, last_word.id, 1'b0});
      end
    end
  end

  // Called at a negedge; issues one finish pulse and runs out the 34-cycle frame.
  task automatic pulse(input logic [15:0] a, input logic [15:0] d, input logic id,
                       input logic fd, input logic with_reinit = 1'b0);
    exp_t e;
    e = '{a: a, d: d, id: id, fd: fd};
    exp_q.push_back(e);
    finish = 1'b1;
    reinit = with_reinit;
    @(negedge sck);
    finish = 1'b0;
    reinit = 1'b0;
    repeat (33) @(negedge sck);
  endtask

  task automatic init_seq(input logic [3:0] inten);
    pulse(16'h0C0C, 16'h0101, 1'b0, 1'b0);
    pulse(16'h0909, 16'h0000, 1'b0, 1'b0);
    pulse(16'h0B0B, 16'h0707, 1'b0, 1'b0);
    pulse(16'h0A0A, {4'h0, inten, 4'h0, inten}, 1'b0, 1'b0);
    intensity = ~inten;  // must not disturb the word already latched
    pulse(16'h0F0F, 16'h0000, 1'b0, 1'b0);
  endtask

  localparam logic [63:0] PAT_P = 64'h8040201008040201;
  localparam logic [63:0] PAT_Q = 64'hA55A3CC30FF01248;

  initial begin
    #3 rst = 1'b1;
    @(negedge sck);
    @(negedge sck);
    rst = 1'b0;
    fb_a = PAT_P;
    fb_b = ~PAT_P;
    intensity = 4'h5;
    repeat (3) @(negedge sck);

    // Pass 1: NOP -> init -> rows of P, wrap with frame_done.
    init_seq(4'h5);
    pulse(16'h0101, 16'h01FE, 1'b1, 1'b0);
    for (int r = 2; r <= 7; r++)
      pulse({8'(r), 8'(r)}, row_word(PAT_P, ~PAT_P, r), 1'b1, 1'b0);
    pulse(16'h0808, 16'h807F, 1'b1, 1'b0);
    pulse(16'h0101, 16'h01FE, 1'b1, 1'b1);

    // Pass 2: change fb_a while in row 4; rows 5..8 keep the old snapshot.
    for (int r = 2; r <= 4; r++)
      pulse({8'(r), 8'(r)}, row_word(PAT_P, ~PAT_P, r), 1'b1, 1'b0);
    fb_a = PAT_Q;
    for (int r = 5; r <= 8; r++)
      pulse({8'(r), 8'(r)}, row_word(PAT_P, ~PAT_P, r), 1'b1, 1'b0);
    pulse(16'h0101, row_word(PAT_Q, ~PAT_P, 1), 1'b1, 1'b1);

    // Pass 3: reinit mid-frame in row 3; word holds until the next finish.
    pulse(16'h0202, row_word(PAT_Q, ~PAT_P, 2), 1'b1, 1'b0);
    pulse(16'h0303, row_word(PAT_Q, ~PAT_P, 3), 1'b1, 1'b0);
    reinit = 1'b1;
    @(negedge sck);
    reinit = 1'b0;
    repeat (4) @(negedge sck);
    intensity = 4'hA;
    init_seq(4'hA);
    for (int r = 1; r <= 8; r++)
      pulse({8'(r), 8'(r)}, row_word(PAT_Q, ~PAT_P, r), 1'b1, 1'b0);

    // Reinit coincident with the finish that leaves row 8: no frame_done.
    intensity = 4'h3;
    pulse(16'h0C0C, 16'h0101, 1'b0, 1'b0, 1'b1);
    pulse(16'h0909, 16'h0000, 1'b0, 1'b0);
    pulse(16'h0B0B, 16'h0707, 1'b0, 1'b0);

    // Asynchronous reset in init index 2, then restart from NOP.
    #2 rst = 1'b1;
    @(negedge sck);
    @(negedge sck);
    rst = 1'b0;
    repeat (5) @(negedge sck);
    pulse(16'h0C0C, 16'h0101, 1'b0, 1'b0);
    pulse(16'h0909, 16'h0000, 1'b0, 1'b0);

    repeat (3) @(negedge sck);
    check("queue_drained", 34'(exp_q.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
